// File: rtl/pwm_pkg.sv
// Shared types and default widths for the multi-channel PWM block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pwm_pkg;

    localparam int PWM_NCH     = 4;
    localparam int PWM_CNT_W   = 16;
    localparam int PWM_PRESC_W = 16;

    typedef enum logic {
        PWM_UP     = 1'b0,
        PWM_UPDOWN = 1'b1
    } pwm_mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } pwm_dir_e;

endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM time-base: prescaler clock-enable, up / up-down counter, period boundary detect.
// Latency: ctr moves one clk after the tick cycle; period_tick is high in the first cycle ctr is back at 0.
// Backpressure: none; enable=0 freezes prescaler, counter and direction exactly.
//
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   enable             run / freeze
//   prescale           tick every prescale+1 cycles (live)
//   period_act         active counter top value
//   mode_act           active counting mode
//   ctr_next           value ctr takes at the next edge (lets callers register outputs aligned with ctr)
//   boundary           this cycle's tick returns the counter to 0
//   period_tick        registered boundary pulse
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int CNT_W   = PWM_CNT_W,
    parameter int PRESC_W = PWM_PRESC_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [PRESC_W-1:0] prescale,
    input  logic [CNT_W-1:0]   period_act,
    input  pwm_mode_e          mode_act,
    output logic [CNT_W-1:0]   ctr_next,
    output logic               boundary,
    output logic               period_tick
);

    localparam logic [CNT_W-1:0]   CTR_ONE   = CNT_W'(1);
    localparam logic [PRESC_W-1:0] PRESC_ONE = PRESC_W'(1);

    logic [PRESC_W-1:0] presc_cnt;
    logic [CNT_W-1:0]   ctr;
    pwm_dir_e           dir;
    pwm_dir_e           dir_next;
    logic               tick;

    // >= rather than == so a live reduction of prescale cannot strand the counter above it.
    assign tick = enable && (presc_cnt >= prescale);

    always_comb begin
        ctr_next = ctr;
        dir_next = dir;
        if (tick) begin
            if (period_act == '0) begin
                ctr_next = '0;
                dir_next = DIR_UP;
            end else if (mode_act == PWM_UP) begin
                ctr_next = (ctr < period_act) ? ctr + CTR_ONE : '0;
                dir_next = DIR_UP;
            end else if (dir == DIR_UP) begin
                if (ctr < period_act) begin
                    ctr_next = ctr + CTR_ONE;
                end else begin
                    ctr_next = ctr - CTR_ONE;
                    dir_next = DIR_DOWN;
                end
            end else begin
                if (ctr > CTR_ONE) begin
                    ctr_next = ctr - CTR_ONE;
                end else begin
                    ctr_next = '0;
                    dir_next = DIR_UP;
                end
            end
        end
    end

    // Includes the 0->0 case when period_act is 0, so a fresh load always gets committed.
    assign boundary = tick && (ctr_next == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_cnt   <= '0;
            ctr         <= '0;
            dir         <= DIR_UP;
            period_tick <= 1'b0;
        end else begin
            if (enable) begin
                presc_cnt <= tick ? '0 : presc_cnt + PRESC_ONE;
            end
            ctr         <= ctr_next;
            dir         <= boundary ? DIR_UP : dir_next;
            period_tick <= boundary;
        end
    end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM with shared time-base, per-channel compare/polarity, shadow regs committed at period boundaries.
// Latency: pwm_out is registered and aligned with the counter; polarity changes appear one clk later.
// Backpressure: none; enable=0 holds all state, load is a single-cycle strobe always accepted.
//
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   enable       run / freeze
//   prescale     live prescaler value
//   load         captures period, mode, cmp into shadow registers
//   period/mode  counter top value and counting mode (shadowed)
//   cmp          per-channel compare, channel i at [i*CNT_W +: CNT_W] (shadowed)
//   polarity     per-channel output inversion (live)
//   pwm_out      registered PWM outputs
//   period_tick  one-cycle pulse in the first cycle of each period
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int NCH     = PWM_NCH,
    parameter int CNT_W   = PWM_CNT_W,
    parameter int PRESC_W = PWM_PRESC_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [PRESC_W-1:0]   prescale,
    input  logic                 load,
    input  logic [CNT_W-1:0]     period,
    input  logic                 mode,
    input  logic [NCH*CNT_W-1:0] cmp,
    input  logic [NCH-1:0]       polarity,
    output logic [NCH-1:0]       pwm_out,
    output logic                 period_tick
);

    logic [CNT_W-1:0] period_sh;
    logic [CNT_W-1:0] period_act;
    pwm_mode_e        mode_sh;
    pwm_mode_e        mode_act;
    logic [CNT_W-1:0] ctr_next;
    logic             boundary;

    // Shadow capture uses this cycle's inputs while the commit takes the previous shadow,
    // so a load coincident with a boundary takes effect one period later.
    always_ff @(posedge clk) begin
        if (rst) begin
            period_sh  <= '0;
            period_act <= '0;
            mode_sh    <= PWM_UP;
            mode_act   <= PWM_UP;
        end else begin
            if (load) begin
                period_sh <= period;
                mode_sh   <= pwm_mode_e'(mode);
            end
            if (boundary) begin
                period_act <= period_sh;
                mode_act   <= mode_sh;
            end
        end
    end

    pwm_timebase #(
        .CNT_W   (CNT_W),
        .PRESC_W (PRESC_W)
    ) u_timebase (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .prescale    (prescale),
        .period_act  (period_act),
        .mode_act    (mode_act),
        .ctr_next    (ctr_next),
        .boundary    (boundary),
        .period_tick (period_tick)
    );

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [CNT_W-1:0] cmp_sh;
        logic [CNT_W-1:0] cmp_act;
        logic [CNT_W-1:0] cmp_next;
        logic             pwm_q;

        assign cmp_next = boundary ? cmp_sh : cmp_act;

        // Output is computed from next-state so it lines up with ctr with no extra cycle.
        always_ff @(posedge clk) begin
            if (rst) begin
                cmp_sh  <= '0;
                cmp_act <= '0;
                pwm_q   <= 1'b0;
            end else begin
                if (load) begin
                    cmp_sh <= cmp[i*CNT_W +: CNT_W];
                end
                if (boundary) begin
                    cmp_act <= cmp_sh;
                end
                pwm_q <= polarity[i] ^ (ctr_next < cmp_next);
            end
        end

        assign pwm_out[i] = pwm_q;
    end

endmodule
